ipv4_hdr_check: RTL and testbench

- Upstream metadata stage for the router output-port-lookup datapath.
- Taps the slave AXIS stream at its handshake point and parses the Ethernet and IPv4 header.
- Checks version/IHL, TTL and header checksum, and computes the checksum after TTL decrement.
- Queues one result record per packet; the forwarding-decision stage pops a record each time it starts consuming a packet.

---
 rtl/ipv4_hdr_check_pkg.sv | 42 ++++
 rtl/csum16_fold.sv | 13 +
 rtl/fallthrough_small_fifo.sv | 55 +++++
 rtl/ipv4_hdr_check.sv | 183 ++++++++++++++++++
 tb/tb_ipv4_hdr_check.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ipv4_hdr_check_pkg.sv
// rtl/ipv4_hdr_check_pkg.sv - shared lanes, states and result record for the IPv4 header checker
package ipv4_hdr_check_pkg;

    // Bit positions (msb of each field) inside a 256-bit beat; byte k sits at [255-8k:248-8k]
    localparam int ETHTYPE_HI = 159;   // beat 0, bytes 12..13
    localparam int VER_IHL_HI = 143;   // beat 0, byte 14
    localparam int TTL_HI     = 79;    // beat 0, byte 22
    localparam int PROTO_HI   = 71;    // beat 0, byte 23
    localparam int CSUM_HI    = 63;    // beat 0, bytes 24..25
    localparam int DADDR_HI0  = 15;    // beat 0, bytes 30..31 (upper half of daddr)
    localparam int DADDR_HI1  = 255;   // beat 1, bytes 32..33 (lower half of daddr)

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  VER_IHL_IPV4   = 8'h45;

    typedef enum logic [1:0] {
        S_HDR0,
        S_HDR1,
        S_SKIP
    } parse_state_t;

    typedef struct packed {
        logic        can_handle;
        logic        ttl_ok;
        logic        csum_ok;
        logic [15:0] csum_updated;
        logic [31:0] daddr;
    } hdr_rec_t;

    localparam int REC_W = $bits(hdr_rec_t);

    // Plain (unfolded) sum of the nine header words carried in beat 0
    function automatic logic [19:0] sum_words9(input logic [143:0] w);
        logic [19:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + {4'h0, w[16*i +: 16]};
        end
        return s;
    endfunction

endpackage

// File: rtl/csum16_fold.sv
// rtl/csum16_fold.sv - fold a 20-bit ones-complement sum to 16 bits with end-around carry
module csum16_fold (
    input  logic [19:0] sum_i,
    output logic [15:0] fold_o
);

    logic [16:0] first_fold;

    // Second add cannot carry again: if the first one carried, its low half is at most 14
    assign first_fold = {1'b0, sum_i[15:0]} + {13'h0, sum_i[19:16]};
    assign fold_o     = first_fold[15:0] + {15'h0, first_fold[16]};

endmodule

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - small first-word-fallthrough queue with occupancy flags
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;
    logic                      push;
    logic                      pop;

    assign empty       = (count_q == '0);
    assign full        = count_q[MAX_DEPTH_BITS];
    assign nearly_full = count_q[MAX_DEPTH_BITS] | (&count_q[MAX_DEPTH_BITS-1:0]);
    assign dout        = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full queue still takes a concurrent push
    assign pop  = rd_en & ~empty;
    assign push = wr_en & (~full | pop);

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at the depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + MAX_DEPTH_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + MAX_DEPTH_BITS'(1);
            count_q <= count_q + (MAX_DEPTH_BITS+1)'(push) - (MAX_DEPTH_BITS+1)'(pop);
        end
    end

endmodule

// File: rtl/ipv4_hdr_check.sv
// rtl/ipv4_hdr_check.sv - tap an AXIS stream, check the IPv4 header, queue one result per packet
module ipv4_hdr_check
    import ipv4_hdr_check_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int QDEPTH_BITS         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                           S_AXIS_TVALID,
    input  logic                           S_AXIS_TREADY,
    input  logic                           S_AXIS_TLAST,
    input  logic                           i_rd_hdr,
    output logic                           o_can_handle_ipv4,
    output logic                           o_ttl_ok,
    output logic                           o_csum_ok,
    output logic [15:0]                    o_csum_updated,
    output logic [31:0]                    o_daddr,
    output logic                           o_valid,
    output logic                           o_nearly_full,
    output logic                           o_overflow
);

    parse_state_t state_q, state_d;
    logic [15:0]  ethtype_q, ethtype_d;
    logic [7:0]   ver_ihl_q, ver_ihl_d;
    logic [7:0]   ttl_q, ttl_d;
    logic [7:0]   proto_q, proto_d;
    logic [15:0]  rx_csum_q, rx_csum_d;
    logic [31:0]  daddr_q, daddr_d;
    logic [19:0]  sum_q, sum_d;
    logic         push_q, push_d;
    logic         short_q, short_d;
    logic         overflow_q;

    logic         accept;
    logic         can_handle;
    logic [15:0]  hdr_fold;
    logic [19:0]  upd_sum;
    logic [15:0]  upd_fold;
    logic [7:0]   ttl_dec;
    hdr_rec_t     rec_in;
    hdr_rec_t     rec_head;
    logic         fifo_full;
    logic         fifo_nearly_full;
    logic         fifo_empty;
    logic         unused_tdata;

    assign accept       = S_AXIS_TVALID & S_AXIS_TREADY;
    assign unused_tdata = ^S_AXIS_TDATA[239:160];

    // Header parser: latch beat-0 fields and partial sum, finish the sum on beat 1, then skip
    always_comb begin
        state_d   = state_q;
        ethtype_d = ethtype_q;
        ver_ihl_d = ver_ihl_q;
        ttl_d     = ttl_q;
        proto_d   = proto_q;
        rx_csum_d = rx_csum_q;
        daddr_d   = daddr_q;
        sum_d     = sum_q;
        push_d    = 1'b0;
        short_d   = 1'b0;
        case (state_q)
            S_HDR0: if (accept) begin
                ethtype_d = S_AXIS_TDATA[ETHTYPE_HI -: 16];
                ver_ihl_d = S_AXIS_TDATA[VER_IHL_HI -: 8];
                ttl_d     = S_AXIS_TDATA[TTL_HI -: 8];
                proto_d   = S_AXIS_TDATA[PROTO_HI -: 8];
                rx_csum_d = S_AXIS_TDATA[CSUM_HI -: 16];
                daddr_d   = {S_AXIS_TDATA[DADDR_HI0 -: 16], 16'h0000};
                sum_d     = sum_words9(S_AXIS_TDATA[VER_IHL_HI:0]);
                if (S_AXIS_TLAST) begin
                    push_d  = 1'b1;
                    short_d = 1'b1;
                end else begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: if (accept) begin
                sum_d   = sum_q + {4'h0, S_AXIS_TDATA[DADDR_HI1 -: 16]};
                daddr_d = {daddr_q[31:16], S_AXIS_TDATA[DADDR_HI1 -: 16]};
                push_d  = 1'b1;
                state_d = S_AXIS_TLAST ? S_HDR0 : S_SKIP;
            end
            S_SKIP: if (accept && S_AXIS_TLAST) begin
                state_d = S_HDR0;
            end
            default: state_d = S_HDR0;
        endcase
    end

    // Parser state and captured header fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HDR0;
            ethtype_q <= '0;
            ver_ihl_q <= '0;
            ttl_q     <= '0;
            proto_q   <= '0;
            rx_csum_q <= '0;
            daddr_q   <= '0;
            sum_q     <= '0;
            push_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ethtype_q <= ethtype_d;
            ver_ihl_q <= ver_ihl_d;
            ttl_q     <= ttl_d;
            proto_q   <= proto_d;
            rx_csum_q <= rx_csum_d;
            daddr_q   <= daddr_d;
            sum_q     <= sum_d;
            push_q    <= push_d;
            short_q   <= short_d;
        end
    end

    assign can_handle = (ethtype_q == ETHERTYPE_IPV4) && (ver_ihl_q == VER_IHL_IPV4);

    // Incremental update for a TTL decrement; a TTL of 0 simply wraps to 0xFF here
    assign ttl_dec = ttl_q - 8'd1;
    assign upd_sum = {4'h0, ~rx_csum_q} + {4'h0, ~{ttl_q, proto_q}} + {4'h0, ttl_dec, proto_q};

    csum16_fold u_fold_hdr (
        .sum_i  (sum_q),
        .fold_o (hdr_fold)
    );

    csum16_fold u_fold_upd (
        .sum_i  (upd_sum),
        .fold_o (upd_fold)
    );

    // Result record; short frames and non-IPv4 packets produce an all-zero record
    always_comb begin
        rec_in = '0;
        if (!short_q && can_handle) begin
            rec_in.can_handle   = 1'b1;
            rec_in.ttl_ok       = (ttl_q > 8'd1);
            rec_in.csum_ok      = (hdr_fold == 16'hFFFF);
            rec_in.csum_updated = ~upd_fold;
            rec_in.daddr        = daddr_q;
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (REC_W),
        .MAX_DEPTH_BITS (QDEPTH_BITS)
    ) u_rec_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (rec_in),
        .wr_en       (push_q),
        .rd_en       (i_rd_hdr),
        .dout        (rec_head),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    // Sticky flag for records lost to a full queue (a concurrent pop makes room)
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !i_rd_hdr) begin
            overflow_q <= 1'b1;
        end
    end

    // Head slot contents are stale while empty, so outputs are masked to zero
    assign o_can_handle_ipv4 = ~fifo_empty & rec_head.can_handle;
    assign o_ttl_ok          = ~fifo_empty & rec_head.ttl_ok;
    assign o_csum_ok         = ~fifo_empty & rec_head.csum_ok;
    assign o_csum_updated    = fifo_empty ? 16'h0000 : rec_head.csum_updated;
    assign o_daddr           = fifo_empty ? 32'h0000_0000 : rec_head.daddr;
    assign o_valid           = ~fifo_empty;
    assign o_nearly_full     = fifo_nearly_full;
    assign o_overflow        = overflow_q;

endmodule

// File: tb/tb_ipv4_hdr_check.sv
// tb/tb_ipv4_hdr_check.sv - directed-vector bench for ipv4_hdr_check
module tb_ipv4_hdr_check;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         rd_hdr;
    logic         can_handle;
    logic         ttl_ok;
    logic         csum_ok;
    logic [15:0]  csum_updated;
    logic [31:0]  daddr;
    logic         valid;
    logic         nearly_full;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [159:0] hdr_a;
    logic [159:0] hdr;

    always #5 clk = ~clk;

    ipv4_hdr_check #(
        .C_S_AXIS_DATA_WIDTH (256),
        .QDEPTH_BITS         (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .S_AXIS_TDATA      (tdata),
        .S_AXIS_TVALID     (tvalid),
        .S_AXIS_TREADY     (tready),
        .S_AXIS_TLAST      (tlast),
        .i_rd_hdr          (rd_hdr),
        .o_can_handle_ipv4 (can_handle),
        .o_ttl_ok          (ttl_ok),
        .o_csum_ok         (csum_ok),
        .o_csum_updated    (csum_updated),
        .o_daddr           (daddr),
        .o_valid           (valid),
        .o_nearly_full     (nearly_full),
        .o_overflow        (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive one packet (bytes 14..33 = h); optionally check o_valid just before/after the push edge
    task automatic send_pkt(input logic [15:0] eth, input logic [159:0] h, input int nbeats,
                            input bit last_on_end, input int lat_beat);
        int tmax;
        tmax = nbeats + 1;
        if (lat_beat >= 0 && lat_beat + 2 > tmax) tmax = lat_beat + 2;
        for (int t = 0; t <= tmax; t++) begin
            @(negedge clk);
            if (lat_beat >= 0 && t == lat_beat + 1) chk("lat_pre_push", valid, 1'b0);
            if (lat_beat >= 0 && t == lat_beat + 2) chk("lat_post_push", valid, 1'b1);
            if (t < nbeats) begin
                tvalid = 1'b1;
                tready = 1'b1;
                tlast  = last_on_end && (t == nbeats - 1);
                if (t == 0)      tdata = {96'h0011_2233_4455_6677_8899_aabb, eth, h[159:16]};
                else if (t == 1) tdata = {h[15:0], {30{8'ha5}}};
                else             tdata = {32{8'h5a}};
            end else begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                tdata  = '0;
            end
        end
    endtask

    task automatic pop();
        @(negedge clk);
        rd_hdr = 1'b1;
        @(negedge clk);
        rd_hdr = 1'b0;
    endtask

    task automatic check_rec(input string tag, input logic e_can, input logic e_ttl, input logic e_ok,
                             input logic [15:0] e_upd, input logic [31:0] e_daddr);
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_can"}, can_handle, e_can);
        chk({tag, "_ttl"}, ttl_ok, e_ttl);
        chk({tag, "_csum_ok"}, csum_ok, e_ok);
        chk({tag, "_csum_upd"}, csum_updated, e_upd);
        chk({tag, "_daddr"}, daddr, e_daddr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        tdata  = '0;
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
        rd_hdr = 1'b0;
        hdr_a  = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                  16'hb861, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};

        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_nearly_full", nearly_full, 1'b0);
        chk("rst_can", can_handle, 1'b0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_csum_upd", csum_updated, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", valid, 1'b0);

        // Good IPv4 header, three beats, latency checked around beat 1
        send_pkt(16'h0800, hdr_a, 3, 1'b1, 1);
        check_rec("good", 1'b1, 1'b1, 1'b1, 16'hb961, 32'hc0a800c7);
        pop();
        chk("good_popped", valid, 1'b0);

        // Corrupted received checksum
        hdr = hdr_a;
        hdr[79:64] = 16'hb862;
        send_pkt(16'h0800, hdr, 3, 1'b1, -1);
        check_rec("badcsum", 1'b1, 1'b1, 1'b0, 16'hb962, 32'hc0a800c7);
        pop();

        // TTL 1 with a matching checksum
        hdr = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h0111,
               16'hf761, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
        send_pkt(16'h0800, hdr, 3, 1'b1, -1);
        check_rec("ttl1", 1'b1, 1'b0, 1'b1, 16'hf861, 32'hc0a800c7);
        pop();

        // IHL 6 is not handled
        hdr = hdr_a;
        hdr[159:144] = 16'h4600;
        send_pkt(16'h0800, hdr, 3, 1'b1, -1);
        check_rec("ihl6", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        pop();

        // ARP ethertype over two beats
        send_pkt(16'h0806, hdr_a, 2, 1'b1, -1);
        check_rec("arp", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        pop();

        // Single-beat frame: zero record pushed the cycle after the beat
        send_pkt(16'h0800, hdr_a, 1, 1'b1, 0);
        check_rec("short", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        pop();
        chk("short_popped", valid, 1'b0);

        // Five packets with no pops: queue holds four, fifth is dropped
        for (int i = 0; i < 5; i++) begin
            hdr = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                   16'hb861 - 16'(i), 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7 + 16'(i)};
            send_pkt(16'h0800, hdr, 2, 1'b1, -1);
            chk($sformatf("fill%0d_nearly_full", i), nearly_full, (i >= 2) ? 1'b1 : 1'b0);
            chk($sformatf("fill%0d_overflow", i), overflow, (i == 4) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            check_rec($sformatf("drain%0d", k), 1'b1, 1'b1, 1'b1,
                      16'hb961 - 16'(k), 32'hc0a800c7 + 32'(k));
            pop();
        end
        chk("drain_empty", valid, 1'b0);
        chk("drain_nearly_full", nearly_full, 1'b0);
        chk("overflow_sticky", overflow, 1'b1);
        pop();
        chk("pop_empty_ignored", valid, 1'b0);

        // Reset while parser is in S_SKIP, then a fresh packet
        send_pkt(16'h0800, hdr_a, 3, 1'b0, -1);
        chk("skip_rec_valid", valid, 1'b1);
        @(negedge clk);
        tvalid = 1'b1;
        tready = 1'b1;
        tdata  = {32{8'h77}};
        reset  = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tdata  = '0;
        reset  = 1'b0;
        chk("rst2_valid", valid, 1'b0);
        chk("rst2_overflow", overflow, 1'b0);
        send_pkt(16'h0800, hdr_a, 3, 1'b1, 1);
        check_rec("after_rst", 1'b1, 1'b1, 1'b1, 16'hb961, 32'hc0a800c7);
        chk("after_rst_overflow", overflow, 1'b0);
        pop();
        chk("final_empty", valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
